// File: rtl/swt16_pkg.sv
// Shared constants and helpers for the swt16 five-stage pipeline (IF, DC, EX, MEM, WB).
// Latency: n/a (declarations only).
// Backpressure: n/a.
package swt16_pkg;

  localparam int SWT16_REG_IDX_WIDTH = 4;
  localparam int SWT16_PC_INCREMENT  = 2;
  localparam int SWT16_PIPE_DEPTH    = 5;
  // A destination can have one pending write in each of EX, MEM and WB.
  localparam int SWT16_MAX_INFLIGHT  = SWT16_PIPE_DEPTH - 2;

  // Width needed to hold 0..max_inflight pending writes.
  function automatic int sb_cnt_width(input int max_inflight);
    return (max_inflight < 1) ? 1 : $clog2(max_inflight + 1);
  endfunction

endpackage

// File: rtl/sb_counter.sv
// Pending-write counter for one architectural register: +1 on issue, -1 on retire.
// Latency: count updates at the rising edge after the event; err is combinational.
// Backpressure: none; saturates at MAX_VAL and at zero, a retire at zero raises err.
module sb_counter #(
  parameter int CNT_WIDTH = 2,
  parameter int MAX_VAL   = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 inc,
  input  logic                 dec,
  output logic [CNT_WIDTH-1:0] cnt,
  output logic                 err
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_VAL);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic dec_eff;

  // A retire only counts when something is actually pending.
  assign dec_eff = dec & (cnt != '0);
  assign err     = dec & (cnt == '0);

  // Issue and retire in the same cycle cancel; otherwise step up or down.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt <= '0;
    end else if (inc && !dec_eff && (cnt != CNT_MAX)) begin
      cnt <= cnt + CNT_ONE;
    end else if (dec_eff && !inc) begin
      cnt <= cnt - CNT_ONE;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Register-hazard scoreboard: counts in-flight writes per register and stalls DC on RAW or full hazards.
// Latency: out_stall is combinational; counters, busy mask, err and perf update at the next rising edge.
// Backpressure: out_stall holds IF/DC; a flush in EX overrides the stall and kills the DC instruction.
module hazard_scoreboard
  import swt16_pkg::*;
#(
  parameter int REG_IDX_WIDTH = SWT16_REG_IDX_WIDTH,
  parameter int MAX_INFLIGHT  = SWT16_MAX_INFLIGHT,
  parameter int CNT_WIDTH     = sb_cnt_width(MAX_INFLIGHT),
  parameter bit WB_BYPASS     = 1'b1,
  parameter bit ZERO_REG      = 1'b0,
  parameter int PERF_WIDTH    = 16,
  localparam int NUM_REGS     = 2 ** REG_IDX_WIDTH
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     in_issue,
  input  logic                     in_issue_write,
  input  logic [REG_IDX_WIDTH-1:0] in_issue_dst_idx,
  input  logic                     in_src1_used,
  input  logic [REG_IDX_WIDTH-1:0] in_src1_idx,
  input  logic                     in_src2_used,
  input  logic [REG_IDX_WIDTH-1:0] in_src2_idx,
  input  logic                     in_flush,
  input  logic                     in_wb_write,
  input  logic [REG_IDX_WIDTH-1:0] in_wb_idx,
  output logic                     out_stall,
  output logic [NUM_REGS-1:0]      out_busy_mask,
  output logic                     out_err,
  output logic [PERF_WIDTH-1:0]    out_stall_cycles
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_INFLIGHT);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] cnt [NUM_REGS];
  logic [NUM_REGS-1:0]  pend;
  logic [NUM_REGS-1:0]  inc_vec;
  logic [NUM_REGS-1:0]  dec_vec;
  logic [NUM_REGS-1:0]  err_vec;
  logic                 hz;
  logic                 full;
  logic                 iss;
  logic                 err_q;
  logic [PERF_WIDTH-1:0] perf_q;

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    // Register 0 is hard-wired to zero when ZERO_REG is set, so it never tracks anything.
    localparam bit TRACKED = !(ZERO_REG && (r == 0));

    logic wb_hit;

    assign wb_hit = in_wb_write && (in_wb_idx == REG_IDX_WIDTH'(r));

    // With write-through, the last pending write landing this cycle is already visible.
    assign pend[r]    = TRACKED && (cnt[r] != '0) &&
                        !(WB_BYPASS && wb_hit && (cnt[r] == CNT_ONE));
    assign inc_vec[r] = TRACKED && iss && (in_issue_dst_idx == REG_IDX_WIDTH'(r));
    assign dec_vec[r] = TRACKED && wb_hit;

    assign out_busy_mask[r] = (cnt[r] != '0);

    sb_counter #(
      .CNT_WIDTH (CNT_WIDTH),
      .MAX_VAL   (MAX_INFLIGHT)
    ) u_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (inc_vec[r]),
      .dec   (dec_vec[r]),
      .cnt   (cnt[r]),
      .err   (err_vec[r])
    );
  end

  // Stall on a pending operand or a saturated destination; a flush discards the DC instruction instead.
  always_comb begin
    hz        = 1'b0;
    full      = 1'b0;
    out_stall = 1'b0;
    iss       = 1'b0;
    hz        = in_issue && ((in_src1_used && pend[in_src1_idx]) ||
                             (in_src2_used && pend[in_src2_idx]));
    full      = in_issue && in_issue_write && (cnt[in_issue_dst_idx] == CNT_MAX) &&
                !(in_wb_write && (in_wb_idx == in_issue_dst_idx));
    out_stall = (hz || full) && !in_flush;
    iss       = in_issue && in_issue_write && !out_stall && !in_flush;
  end

  // Sticky flag: some retire arrived for a register with nothing pending.
  always_ff @(posedge clock) begin
    if (reset) begin
      err_q <= 1'b0;
    end else if (|err_vec) begin
      err_q <= 1'b1;
    end
  end

  // Saturating count of stalled cycles for performance monitoring.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_q <= '0;
    end else if (out_stall && (perf_q != {PERF_WIDTH{1'b1}})) begin
      perf_q <= perf_q + PERF_WIDTH'(1);
    end
  end

  assign out_err          = err_q;
  assign out_stall_cycles = perf_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (bypass/no-zero-reg, no-bypass/zero-reg/4-bit perf).
// Latency: stall checked combinationally, state checked #1 after each rising edge.
// Backpressure: stimulus ignores stall except as the model dictates.
module tb_hazard_scoreboard;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       in_issue, in_issue_write, in_src1_used, in_src2_used, in_flush, in_wb_write;
  logic [3:0] in_issue_dst_idx, in_src1_idx, in_src2_idx, in_wb_idx;

  logic        stall_a, err_a, stall_b, err_b;
  logic [15:0] busy_a, busy_b, perf_a;
  logic [3:0]  perf_b;

  hazard_scoreboard #(
    .WB_BYPASS (1'b1), .ZERO_REG (1'b0), .PERF_WIDTH (16)
  ) dut_a (
    .clock (clock), .reset (reset),
    .in_issue (in_issue), .in_issue_write (in_issue_write), .in_issue_dst_idx (in_issue_dst_idx),
    .in_src1_used (in_src1_used), .in_src1_idx (in_src1_idx),
    .in_src2_used (in_src2_used), .in_src2_idx (in_src2_idx),
    .in_flush (in_flush), .in_wb_write (in_wb_write), .in_wb_idx (in_wb_idx),
    .out_stall (stall_a), .out_busy_mask (busy_a), .out_err (err_a), .out_stall_cycles (perf_a)
  );

  hazard_scoreboard #(
    .WB_BYPASS (1'b0), .ZERO_REG (1'b1), .PERF_WIDTH (4)
  ) dut_b (
    .clock (clock), .reset (reset),
    .in_issue (in_issue), .in_issue_write (in_issue_write), .in_issue_dst_idx (in_issue_dst_idx),
    .in_src1_used (in_src1_used), .in_src1_idx (in_src1_idx),
    .in_src2_used (in_src2_used), .in_src2_idx (in_src2_idx),
    .in_flush (in_flush), .in_wb_write (in_wb_write), .in_wb_idx (in_wb_idx),
    .out_stall (stall_b), .out_busy_mask (busy_b), .out_err (err_b), .out_stall_cycles (perf_b)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model: instance 0 = bypass, instance 1 = zero-reg ----------------
  int mcnt [2][16];
  bit merr [2];
  int mperf[2];

  function automatic bit byp(int k);      return k == 0;           endfunction
  function automatic bit zr(int k);       return k == 1;           endfunction
  function automatic int perf_max(int k); return (k == 0) ? 65535 : 15; endfunction

  function automatic bit m_pend(int k, int r);
    if (zr(k) && r == 0) return 1'b0;
    if (byp(k) && in_wb_write && int'(in_wb_idx) == r && mcnt[k][r] == 1) return 1'b0;
    return mcnt[k][r] != 0;
  endfunction

  function automatic bit m_stall(int k);
    bit hz, full;
    hz   = in_issue && ((in_src1_used && m_pend(k, int'(in_src1_idx))) ||
                        (in_src2_used && m_pend(k, int'(in_src2_idx))));
    full = in_issue && in_issue_write && mcnt[k][in_issue_dst_idx] == 3 &&
           !(in_wb_write && in_wb_idx == in_issue_dst_idx);
    return (hz || full) && !in_flush;
  endfunction

  function automatic logic [15:0] m_busy(int k);
    logic [15:0] m;
    m = '0;
    for (int r = 0; r < 16; r++) m[r] = (mcnt[k][r] != 0);
    return m;
  endfunction

  task automatic m_clock();
    for (int k = 0; k < 2; k++) begin
      bit st, iss, ret, trk_wb;
      int d, w;
      if (reset) begin
        for (int r = 0; r < 16; r++) mcnt[k][r] = 0;
        merr[k]  = 1'b0;
        mperf[k] = 0;
      end else begin
        st     = m_stall(k);
        d      = int'(in_issue_dst_idx);
        w      = int'(in_wb_idx);
        iss    = in_issue && in_issue_write && !st && !in_flush && !(zr(k) && d == 0);
        trk_wb = in_wb_write && !(zr(k) && w == 0);
        ret    = trk_wb && mcnt[k][w] != 0;
        if (trk_wb && mcnt[k][w] == 0) merr[k] = 1'b1;
        if (st && mperf[k] < perf_max(k)) mperf[k]++;
        if (!(iss && ret && d == w)) begin
          if (iss) mcnt[k][d]++;
          if (ret) mcnt[k][w]--;
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    m_clock();
    #1;
  endtask

  task automatic chk_model_pre();
    chk("model_stall_a", stall_a, m_stall(0));
    chk("model_stall_b", stall_b, m_stall(1));
  endtask

  task automatic chk_model_post();
    chk("model_busy_a", busy_a, m_busy(0));
    chk("model_busy_b", busy_b, m_busy(1));
    chk("model_err_a", err_a, merr[0]);
    chk("model_err_b", err_b, merr[1]);
    chk("model_perf_a", perf_a, mperf[0]);
    chk("model_perf_b", perf_b, mperf[1][3:0]);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    bit rst, iss, wr; int dst; bit s1u; int s1; bit fl, wbw; int wbi;
    bit st_a, st_b; int busy_a, busy_b; bit err_a, err_b; int perf_a, perf_b;
  } vec_t;

  vec_t tbl[26];

  initial begin
    //          rst iss wr dst s1u s1 fl wbw wbi  st_a st_b busy_a busy_b err_a err_b perf_a perf_b
    tbl[0]  = '{1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 'h00, 'h00, 0, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 'h00, 'h00, 0, 0, 0, 0};
    tbl[2]  = '{0, 1, 0, 0, 1, 3, 0, 0, 0,   0, 0, 'h00, 'h00, 0, 0, 0, 0};
    tbl[3]  = '{0, 1, 1, 5, 0, 0, 0, 0, 0,   0, 0, 'h20, 'h20, 0, 0, 0, 0};
    tbl[4]  = '{0, 1, 0, 0, 1, 5, 0, 0, 0,   1, 1, 'h20, 'h20, 0, 0, 1, 1};
    tbl[5]  = '{0, 1, 0, 0, 1, 5, 0, 0, 0,   1, 1, 'h20, 'h20, 0, 0, 2, 2};
    tbl[6]  = '{0, 1, 0, 0, 1, 5, 0, 1, 5,   0, 1, 'h00, 'h00, 0, 0, 2, 3};
    tbl[7]  = '{0, 1, 0, 0, 1, 5, 0, 0, 0,   0, 0, 'h00, 'h00, 0, 0, 2, 3};
    tbl[8]  = '{0, 1, 1, 2, 0, 0, 0, 0, 0,   0, 0, 'h04, 'h04, 0, 0, 2, 3};
    tbl[9]  = '{0, 1, 1, 2, 0, 0, 0, 0, 0,   0, 0, 'h04, 'h04, 0, 0, 2, 3};
    tbl[10] = '{0, 1, 1, 2, 0, 0, 0, 0, 0,   0, 0, 'h04, 'h04, 0, 0, 2, 3};
    tbl[11] = '{0, 1, 1, 2, 0, 0, 0, 0, 0,   1, 1, 'h04, 'h04, 0, 0, 3, 4};
    tbl[12] = '{0, 1, 1, 2, 0, 0, 0, 1, 2,   0, 0, 'h04, 'h04, 0, 0, 3, 4};
    tbl[13] = '{0, 0, 0, 0, 0, 0, 0, 1, 2,   0, 0, 'h04, 'h04, 0, 0, 3, 4};
    tbl[14] = '{0, 0, 0, 0, 0, 0, 0, 1, 2,   0, 0, 'h04, 'h04, 0, 0, 3, 4};
    tbl[15] = '{0, 0, 0, 0, 0, 0, 0, 1, 2,   0, 0, 'h00, 'h00, 0, 0, 3, 4};
    tbl[16] = '{0, 1, 1, 7, 0, 0, 0, 0, 0,   0, 0, 'h80, 'h80, 0, 0, 3, 4};
    tbl[17] = '{0, 1, 1, 8, 1, 7, 1, 0, 0,   0, 0, 'h80, 'h80, 0, 0, 3, 4};
    tbl[18] = '{0, 0, 0, 0, 0, 0, 0, 1, 7,   0, 0, 'h00, 'h00, 0, 0, 3, 4};
    tbl[19] = '{0, 0, 0, 0, 0, 0, 0, 1, 9,   0, 0, 'h00, 'h00, 1, 1, 3, 4};
    tbl[20] = '{0, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 'h00, 'h00, 1, 1, 3, 4};
    tbl[21] = '{1, 1, 1, 4, 0, 0, 0, 1, 9,   0, 0, 'h00, 'h00, 0, 0, 0, 0};
    tbl[22] = '{0, 1, 1, 0, 0, 0, 0, 0, 0,   0, 0, 'h01, 'h00, 0, 0, 0, 0};
    tbl[23] = '{0, 1, 1, 0, 1, 0, 0, 0, 0,   1, 0, 'h01, 'h00, 0, 0, 1, 0};
    tbl[24] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 'h00, 'h00, 0, 0, 1, 0};
    tbl[25] = '{0, 0, 0, 0, 0, 0, 0, 1, 0,   0, 0, 'h00, 'h00, 1, 0, 1, 0};

    reset = 1'b1;
    in_issue = 0; in_issue_write = 0; in_issue_dst_idx = 0;
    in_src1_used = 0; in_src1_idx = 0; in_src2_used = 0; in_src2_idx = 0;
    in_flush = 0; in_wb_write = 0; in_wb_idx = 0;
    step();
    step();

    for (int i = 0; i < 26; i++) begin
      reset            = tbl[i].rst;
      in_issue         = tbl[i].iss;
      in_issue_write   = tbl[i].wr;
      in_issue_dst_idx = 4'(tbl[i].dst);
      in_src1_used     = tbl[i].s1u;
      in_src1_idx      = 4'(tbl[i].s1);
      in_src2_used     = 1'b0;
      in_src2_idx      = 4'd0;
      in_flush         = tbl[i].fl;
      in_wb_write      = tbl[i].wbw;
      in_wb_idx        = 4'(tbl[i].wbi);
      #1;
      chk($sformatf("vec%0d_stall_a", i), stall_a, tbl[i].st_a);
      chk($sformatf("vec%0d_stall_b", i), stall_b, tbl[i].st_b);
      chk_model_pre();
      step();
      chk($sformatf("vec%0d_busy_a", i), busy_a, tbl[i].busy_a[15:0]);
      chk($sformatf("vec%0d_busy_b", i), busy_b, tbl[i].busy_b[15:0]);
      chk($sformatf("vec%0d_err_a", i), err_a, tbl[i].err_a);
      chk($sformatf("vec%0d_err_b", i), err_b, tbl[i].err_b);
      chk($sformatf("vec%0d_perf_a", i), perf_a, tbl[i].perf_a[15:0]);
      chk($sformatf("vec%0d_perf_b", i), perf_b, tbl[i].perf_b[3:0]);
      chk_model_post();
    end

    // ---------------- randomized traffic against the model ----------------
    for (int c = 0; c < 3000; c++) begin
      reset            = ($urandom_range(0, 149) == 0);
      in_issue         = ($urandom_range(0, 9) < 7);
      in_issue_write   = $urandom_range(0, 1) != 0;
      in_issue_dst_idx = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
      in_src1_used     = $urandom_range(0, 1) != 0;
      in_src1_idx      = 4'($urandom_range(0, 3));
      in_src2_used     = $urandom_range(0, 1) != 0;
      in_src2_idx      = 4'($urandom_range(0, 3));
      in_flush         = ($urandom_range(0, 9) == 0);
      in_wb_write      = ($urandom_range(0, 9) < 4);
      in_wb_idx        = 4'($urandom_range(0, 3));
      #1;
      chk_model_pre();
      step();
      chk_model_post();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Register-hazard scoreboard for the swt16 five-stage pipeline (IF, DC, EX, MEM, WB). It counts in-flight writes per architectural register and stalls the decode stage while an operand it needs is still pending. Register count, pipeline depth, writeback bypass and a hard-wired zero register are all parameters. It sits beside the decoder: issue information comes in from DC, retire information comes in from WB, and the stall goes back to fetch and decode.

## Interface
Parameters:
- REG_IDX_WIDTH, 4, register index width; NUM_REGS = 2**REG_IDX_WIDTH.
- MAX_INFLIGHT, 3, maximum pending writes per register (EX+MEM+WB); must be ≥1.
- CNT_WIDTH, $clog2(MAX_INFLIGHT+1), derived width of each pending counter; not to be overridden.
- WB_BYPASS, 1, 1 = regfile write-through, so a same-cycle WB write clears the hazard.
- ZERO_REG, 0, 1 = register 0 is never tracked and never causes a stall.
- PERF_WIDTH, 16, width of the stall-cycle counter.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- in_issue  in  1  DC holds a valid instruction requesting issue.
- in_issue_write  in  1  that instruction writes a register.
- in_issue_dst_idx  in  REG_IDX_WIDTH  destination register.
- in_src1_used / in_src2_used  in  1 each  operand read enables.
- in_src1_idx / in_src2_idx  in  REG_IDX_WIDTH each  operand indices.
- in_flush  in  1  branch taken in EX; the DC instruction is killed.
- in_wb_write  in  1  WB writes the register file this cycle.
- in_wb_idx  in  REG_IDX_WIDTH  WB destination.
- out_stall  out  1  hold IF/DC; do not issue (combinational).
- out_busy_mask  out  NUM_REGS  bit r = pending count of r nonzero (registered state).
- out_err  out  1  sticky: a retire arrived for a register whose count was 0.
- out_stall_cycles  out  PERF_WIDTH  saturating count of stalled cycles.

## Operation
- Per-register counter cnt[r] (CNT_WIDTH).
- pend(r) = cnt[r]≠0, except:
  - WB_BYPASS=1 and in_wb_write and in_wb_idx==r and cnt[r]==1 → treated as not pending.
  - ZERO_REG=1 and r==0 → never pending.
- Stall conditions:
  - hz = in_issue & ((in_src1_used & pend(src1)) | (in_src2_used & pend(src2))).
  - full = in_issue & in_issue_write & cnt[dst]==MAX_INFLIGHT & ~(in_wb_write & in_wb_idx==dst).
  - out_stall = (hz | full) & ~in_flush. A flush overrides a stall, because the DC instruction is discarded anyway.
- Effective events:
  - iss = in_issue & in_issue_write & ~out_stall & ~in_flush, excluding dst 0 when ZERO_REG=1.
  - ret = in_wb_write & cnt[in_wb_idx]≠0, excluding index 0 when ZERO_REG=1.
- Counter update:
  - iss only → cnt[dst]+1.
  - ret only → cnt[wb_idx]−1.
  - Both on the same register → unchanged.
  - Both on different registers → both update.
- Retire with cnt==0 (tracked register): counter stays 0, out_err sets and holds until reset.
- Instructions already past DC always retire, so a flush never changes any counter.
- out_stall_cycles increments when out_stall=1 and saturates at all-ones.

## Timing
- Reset values: all cnt=0, out_busy_mask=0, out_err=0, out_stall_cycles=0. out_stall=0 because nothing is pending.
- Reset asserted mid-operation clears all state at the next edge and overrides any concurrent issue or retire.
- out_stall is combinational from the inputs and the current counters in the same cycle; there is no added latency.
- Counters and out_busy_mask update at the rising edge after the event.
- Back-to-back dependency (issue of x, next cycle a read of x): stalls until the cycle x is in WB (WB_BYPASS=1) or the cycle after it (WB_BYPASS=0).
- With MAX_INFLIGHT=3, a dependent instruction right behind its producer stalls 2 cycles with bypass and 3 cycles without.

## Structure
- Shared package swt16_pkg holds:
  - Default parameter constants (REG_IDX_WIDTH, PC_INCREMENT, pipeline depth).
  - The function that computes CNT_WIDTH.
- Single sub-module sb_counter: one up/down saturating counter with inc/dec/err outputs, instantiated NUM_REGS times via generate.
- Stall logic and the perf counter live in the top of the block.

## Test plan
- Reset, then idle, then an issue reading r3 with nothing pending → out_stall=0, busy_mask=0, out_err=0.
- Issue write r5, next cycle issue read r5, WB_BYPASS=1 → stall for 2 cycles, then issue; busy_mask bit5 clears the edge after r5 retires; out_stall_cycles=2.
- Same sequence with WB_BYPASS=0 → stall for 3 cycles, out_stall_cycles=3.
- Three back-to-back writes to r2, then a fourth write to r2 with no retire → fourth write stalls (full); cnt[2]=3. When a retire of r2 arrives in the same cycle, the fourth write issues and cnt stays 3.
- Hazard stall on r7 with in_flush=1 in the same cycle → out_stall=0, no counter change.
- Retire of r9 with cnt[9]=0 → out_err=1 and stays 1; cnt[9] stays 0. With ZERO_REG=1, writes and reads of r0 never stall and never set out_err.
